// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with IF/ID register, register file, immediate/control decode and load-use stall
module id_stage #(
    parameter int XLEN = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    input  logic                  ex_mem_read_i,
    input  logic [4:0]            ex_rd_i,
    input  logic                  wb_wen_i,
    input  logic [4:0]            wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [2:0]            funct3_o,
    output logic                  funct7b5_o,
    output logic                  reg_wen_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  branch_o,
    output logic                  jal_o,
    output logic                  jalr_o,
    output logic                  alu_src_imm_o,
    output logic                  lui_o,
    output logic                  auipc_o,
    output logic                  illegal_o
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  valid;
    logic [XLEN-1:0]       rf [32];
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic known, uses_rs1, uses_rs2, ok;
    logic signed [11:0] imm_i, imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush_i) begin
            instr <= NOP_INSTR;
            pc    <= pc_i;
            valid <= 1'b0;
        end else if (!stall_o) begin
            instr <= instr_i;
            pc    <= pc_i;
            valid <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        else if (wb_wen_i && wb_rd_i != 5'd0)
            rf[wb_rd_i] <= wb_data_i;
    end
    assign rs1_o      = instr[19:15];
    assign rs2_o      = instr[24:20];
    assign rd_o       = instr[11:7];
    assign funct3_o   = instr[14:12];
    assign funct7b5_o = instr[30];
    assign pc_o       = pc;
    // write-through lets a same-cycle write-back reach the decoder without an extra forward path
    assign rs1_data_o = rs1_o == 5'd0 ? '0 : (wb_wen_i && wb_rd_i == rs1_o) ? wb_data_i : rf[rs1_o];
    assign rs2_data_o = rs2_o == 5'd0 ? '0 : (wb_wen_i && wb_rd_i == rs2_o) ? wb_data_i : rf[rs2_o];
    always_comb begin
        is_lui    = instr[6:0] == OP_LUI;
        is_auipc  = instr[6:0] == OP_AUIPC;
        is_jal    = instr[6:0] == OP_JAL;
        is_jalr   = instr[6:0] == OP_JALR;
        is_branch = instr[6:0] == OP_BRANCH;
        is_load   = instr[6:0] == OP_LOAD;
        is_store  = instr[6:0] == OP_STORE;
        is_opimm  = instr[6:0] == OP_IMM;
        is_op     = instr[6:0] == OP_OP;
        known     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
        uses_rs1  = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
        uses_rs2  = is_branch | is_store | is_op;
    end
    always_comb begin
        imm_i = instr[31:20];
        imm_s = {instr[31:25], instr[11:7]};
        imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_o = (is_lui | is_auipc)            ? XLEN'(imm_u) :
                is_jal                         ? XLEN'(imm_j) :
                is_branch                      ? XLEN'(imm_b) :
                is_store                       ? XLEN'(imm_s) :
                (is_jalr | is_load | is_opimm) ? XLEN'(imm_i) : '0;
    end
    // a bubble, a stalled or an illegal instruction must not reach EX with any side effect
    always_comb begin
        stall_o       = valid & ex_mem_read_i & (ex_rd_i != 5'd0) &
                        ((uses_rs1 & (ex_rd_i == rs1_o)) | (uses_rs2 & (ex_rd_i == rs2_o)));
        illegal_o     = valid & ~known;
        ok            = valid & ~stall_o & known;
        valid_o       = ok;
        reg_wen_o     = ok & (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op);
        mem_read_o    = ok & is_load;
        mem_write_o   = ok & is_store;
        branch_o      = ok & is_branch;
        jal_o         = ok & is_jal;
        jalr_o        = ok & is_jalr;
        alu_src_imm_o = ok & ~(is_branch | is_op);
        lui_o         = ok & is_lui;
        auipc_o       = ok & is_auipc;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage against a behavioural decode-stage model
module tb_id_stage;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                           BR = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011,
                           OP = 7'b0110011;
    logic clk = 1'b0;
    logic rst_n, flush_i, ex_mem_read_i, wb_wen_i;
    logic [31:0] instr_i, pc_i, wb_data_i;
    logic [4:0] ex_rd_i, wb_rd_i;
    logic stall_o, valid_o, funct7b5_o, illegal_o;
    logic reg_wen_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o, alu_src_imm_o, lui_o, auipc_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0] rs1_o, rs2_o, rd_o;
    logic [2:0] funct3_o;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [14:0] idx;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  fn;
        logic [9:0]  ctrl;
    } exp_t;

    exp_t q[$];
    int compared = 0, mismatched = 0;
    logic [31:0] m_instr, m_pc;
    logic m_valid;
    logic [31:0] m_rf [32];

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i), .wb_wen_i(wb_wen_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .rd_o(rd_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .reg_wen_o(reg_wen_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .alu_src_imm_o(alu_src_imm_o), .lui_o(lui_o), .auipc_o(auipc_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // sign-extend an n-bit field held zero-extended in v
    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'd1 << (n - 1);
        return (v ^ m) - m;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        case (i[6:0])
            LUI, AUIPC:        return {i[31:12], 12'b0};
            JAL:               return sx({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            BR:                return sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            STORE:             return sx({20'b0, i[31:25], i[11:7]}, 12);
            JALR, LOAD, OPIMM: return sx({20'b0, i[31:20]}, 12);
            default:           return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_wen_i && wb_rd_i == r) return wb_data_i;
        return m_rf[r];
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic [6:0] op;
        logic [4:0] r1, r2;
        logic k, u1, u2, ok;
        op = m_instr[6:0];
        r1 = m_instr[19:15];
        r2 = m_instr[24:20];
        k  = op inside {LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP};
        u1 = op inside {JALR, BR, LOAD, STORE, OPIMM, OP};
        u2 = op inside {BR, STORE, OP};
        e.stall = m_valid && ex_mem_read_i && ex_rd_i != 5'd0 &&
                  ((u1 && ex_rd_i == r1) || (u2 && ex_rd_i == r2));
        ok      = m_valid && !e.stall && k;
        e.valid = ok;
        e.pc    = m_pc;
        e.idx   = {r1, r2, m_instr[11:7]};
        e.d1    = rd_reg(r1);
        e.d2    = rd_reg(r2);
        e.imm   = imm_of(m_instr);
        e.fn    = {m_instr[14:12], m_instr[30]};
        e.ctrl  = ok ? {op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}, op == LOAD, op == STORE,
                        op == BR, op == JAL, op == JALR, !(op inside {BR, OP}), op == LUI, op == AUIPC, 1'b0}
                     : {9'b0, m_valid && !k};
        return e;
    endfunction

    // advance the model across one clock edge using the inputs that were present before it
    task automatic model_step();
        logic st;
        st = expect_now().stall;
        if (!rst_n) begin
            m_instr = NOP;
            m_pc    = 32'd0;
            m_valid = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (wb_wen_i && wb_rd_i != 5'd0) m_rf[wb_rd_i] = wb_data_i;
            if (flush_i) begin
                m_instr = NOP;
                m_pc    = pc_i;
                m_valid = 1'b0;
            end else if (!st) begin
                m_instr = instr_i;
                m_pc    = pc_i;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rn, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                        input logic mr, input logic [4:0] er, input logic ww, input logic [4:0] wr,
                        input logic [31:0] wd);
        @(posedge clk);
        model_step();
        #1;
        rst_n = rn; instr_i = ins; pc_i = pc; flush_i = fl;
        ex_mem_read_i = mr; ex_rd_i = er; wb_wen_i = ww; wb_rd_i = wr; wb_data_i = wd;
        q.push_back(expect_now());
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        compared++;
        if (a !== x) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", 32'(stall_o), 32'(e.stall));
            chk("valid", 32'(valid_o), 32'(e.valid));
            chk("pc", pc_o, e.pc);
            chk("rs1/rs2/rd", 32'({rs1_o, rs2_o, rd_o}), 32'(e.idx));
            chk("rs1_data", rs1_data_o, e.d1);
            chk("rs2_data", rs2_data_o, e.d2);
            chk("imm", imm_o, e.imm);
            chk("funct", 32'({funct3_o, funct7b5_o}), 32'(e.fn));
            chk("ctrl", 32'({reg_wen_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o,
                             alu_src_imm_o, lui_o, auipc_o, illegal_o}), 32'(e.ctrl));
        end
    end

    initial begin
        logic [6:0] ops [9];
        logic [31:0] ins;
        ops = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP};
        rst_n = 1'b0; instr_i = 32'd0; pc_i = 32'd0; flush_i = 1'b0; ex_mem_read_i = 1'b0;
        ex_rd_i = 5'd0; wb_wen_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h00500093, 32'h10, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'hFE208EE3, 32'h14, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h002081B3, 32'h18, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h00000013, 32'h1C, 0, 1, 1, 0, 0, 32'h0);
        step(1, 32'h00000013, 32'h1C, 0, 1, 1, 0, 0, 32'h0);
        step(1, 32'h00000013, 32'h1C, 0, 0, 0, 1, 1, 32'hDEADBEEF);
        step(1, 32'h002081B3, 32'h20, 0, 0, 0, 1, 0, 32'h1234);
        step(1, 32'h00000033, 32'h24, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h002081B3, 32'h28, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h0000007F, 32'h2C, 1, 1, 1, 0, 0, 32'h0);
        step(1, 32'h0000007F, 32'h30, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h00008033, 32'h34, 0, 0, 0, 0, 0, 32'h0);
        step(0, 32'h00008033, 32'h38, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h00008033, 32'h3C, 0, 0, 0, 0, 0, 32'h0);
        step(1, 32'h00000013, 32'h40, 0, 0, 0, 0, 0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            ins[6:0] = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ins[11:7]  = 5'($urandom_range(0, 7));
            step($urandom_range(0, 99) != 0, ins, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
